// File: rtl/optical_tx_arbiter.sv
// ---------------------------------------------------------------------------
// optical_tx_arbiter
//
// Merges an audio stream (port a) and a bulk/SD stream (port b) into a single
// framed stream for an optical serializer, inserting a sync frame after every
// SYNC_PERIOD data frames and as the very first frame after reset.
//
// Frame format on ser_data: {tag[1:0], payload[7:0]}
//   2'b01 audio, 2'b10 bulk, 2'b11 sync (payload SYNC_WORD). 2'b00 never valid.
//
// Ports
//   clk_100mhz  in   system clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req_a       in   audio word present on data_a
//   data_a[7:0] in   audio payload, stable while req_a until ack_a
//   ack_a       out  data_a captured this cycle (combinational)
//   req_b       in   bulk word present on data_b
//   data_b[7:0] in   bulk payload, stable while req_b until ack_b
//   ack_b       out  data_b captured this cycle (combinational)
//   ser_valid   out  ser_data holds a frame
//   ser_data    out  10-bit frame
//   ser_ready   in   serializer takes ser_data this cycle when ser_valid
//
// Handshake: the output side is strict valid/ready. Once ser_valid is high,
// ser_data is frozen until a cycle with ser_ready=1; only then (or while the
// register is empty) does the register load. Requesters are acked in exactly
// the cycle their word is loaded, so a request that drops before that cycle
// leaves no trace.
//
// Optional feature: define OPTICAL_TX_FAIR_EN to compile in the audio burst
// limiter that forces a bulk grant after MAX_BURST audio grants while bulk
// waits. Without it, audio has strict priority.
// ---------------------------------------------------------------------------
module optical_tx_arbiter #(
    parameter int         SYNC_PERIOD = 64,
    parameter logic [7:0] SYNC_WORD   = 8'hA5,
    parameter int         MAX_BURST   = 4
) (
    input  logic       clk_100mhz,
    input  logic       rst_n,
    input  logic       req_a,
    input  logic [7:0] data_a,
    output logic       ack_a,
    input  logic       req_b,
    input  logic [7:0] data_b,
    output logic       ack_b,
    output logic       ser_valid,
    output logic [9:0] ser_data,
    input  logic       ser_ready
);

    localparam logic STATE_IDLE = 1'b0;
    localparam logic STATE_HOLD = 1'b1;

    localparam logic [1:0] TAG_AUDIO = 2'b01;
    localparam logic [1:0] TAG_BULK  = 2'b10;
    localparam logic [1:0] TAG_SYNC  = 2'b11;

    localparam logic [7:0] SYNC_LIMIT  = 8'(SYNC_PERIOD);
    localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

`ifdef OPTICAL_TX_FAIR_EN
    localparam bit FAIR_EN = 1'b1;
`else
    localparam bit FAIR_EN = 1'b0;
`endif

    logic       state;
    logic       state_next;
    logic [9:0] data_q;
    logic [7:0] frame_cnt;
    logic       first_after_reset;
    logic [3:0] burst_cnt;

    logic       load;
    logic       sync_due;
    logic       force_b;
    logic       grant_a;
    logic       grant_b;

    // The FSM state is the valid flag itself.
    assign ser_valid = (state == STATE_HOLD);
    assign ser_data  = data_q;

    assign load     = !ser_valid || ser_ready;
    assign sync_due = (frame_cnt == SYNC_LIMIT) || first_after_reset;
    assign force_b  = FAIR_EN && req_b && (burst_cnt == BURST_LIMIT);

    // Grant priority below sync: forced bulk, audio, bulk.
    always_comb begin
        grant_a = 1'b0;
        grant_b = 1'b0;
        if (!sync_due) begin
            if (force_b) begin
                grant_b = 1'b1;
            end else if (req_a) begin
                grant_a = 1'b1;
            end else if (req_b) begin
                grant_b = 1'b1;
            end
        end
    end

    // Acks are masked during reset because load is high there (register empty).
    assign ack_a = rst_n && load && grant_a;
    assign ack_b = rst_n && load && grant_b;

    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE: if (sync_due || grant_a || grant_b) state_next = STATE_HOLD;
            STATE_HOLD: if (ser_ready && !(sync_due || grant_a || grant_b)) state_next = STATE_IDLE;
            default:    state_next = STATE_IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            state             <= STATE_IDLE;
            data_q            <= 10'h000;
            frame_cnt         <= 8'd0;
            first_after_reset <= 1'b1;
        end else begin
            state <= state_next;
            if (load) begin
                if (sync_due) begin
                    data_q            <= {TAG_SYNC, SYNC_WORD};
                    frame_cnt         <= 8'd0;
                    first_after_reset <= 1'b0;
                end else if (grant_a) begin
                    data_q    <= {TAG_AUDIO, data_a};
                    frame_cnt <= frame_cnt + 8'd1;
                end else if (grant_b) begin
                    data_q    <= {TAG_BULK, data_b};
                    frame_cnt <= frame_cnt + 8'd1;
                end
            end
        end
    end

    // Burst counter: audio grants in a row while bulk is waiting. Held at zero
    // when the fairness feature is compiled out.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            burst_cnt <= 4'd0;
        end else if (!FAIR_EN || !req_b) begin
            burst_cnt <= 4'd0;
        end else if (load && grant_b) begin
            burst_cnt <= 4'd0;
        end else if (load && grant_a) begin
            burst_cnt <= burst_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_optical_tx_arbiter.sv
// ---------------------------------------------------------------------------
// tb_optical_tx_arbiter
//
// Directed bench for optical_tx_arbiter built with SYNC_PERIOD=4 so that sync
// insertion shows up in short sequences. Inputs change 1 ns after the rising
// edge; outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_optical_tx_arbiter;

    logic       clk_100mhz;
    logic       rst_n;
    logic       req_a;
    logic [7:0] data_a;
    logic       ack_a;
    logic       req_b;
    logic [7:0] data_b;
    logic       ack_b;
    logic       ser_valid;
    logic [9:0] ser_data;
    logic       ser_ready;

    int n_vec;
    int n_fail;

    logic [9:0] exp_q[$];

    optical_tx_arbiter #(
        .SYNC_PERIOD(4),
        .SYNC_WORD  (8'hA5),
        .MAX_BURST  (4)
    ) dut (
        .clk_100mhz(clk_100mhz),
        .rst_n     (rst_n),
        .req_a     (req_a),
        .data_a    (data_a),
        .ack_a     (ack_a),
        .req_b     (req_b),
        .data_b    (data_b),
        .ack_b     (ack_b),
        .ser_valid (ser_valid),
        .ser_data  (ser_data),
        .ser_ready (ser_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    task automatic tick();
        @(posedge clk_100mhz);
        #1;
    endtask

    task automatic reset_dut();
        rst_n     = 1'b0;
        req_a     = 1'b0;
        req_b     = 1'b0;
        data_a    = 8'h00;
        data_b    = 8'h00;
        ser_ready = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [9:0] act, input logic [9:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Hold the requests and ser_ready=1 for a number of cycles; every transfer
    // is checked against exp_q, and acks are counted.
    task automatic run_stream(input string tag, input int cycles, input logic ra, input logic rb,
                              output int acks_a, output int acks_b);
        logic [9:0] e;
        acks_a    = 0;
        acks_b    = 0;
        req_a     = ra;
        req_b     = rb;
        data_a    = 8'hAA;
        data_b    = 8'hBB;
        ser_ready = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk_100mhz);
            if (ser_valid && ser_ready) begin
                if (exp_q.size() == 0) begin
                    chk($sformatf("%s extra frame c%0d", tag, c), ser_data, 10'h000);
                end else begin
                    e = exp_q.pop_front();
                    chk($sformatf("%s frame c%0d", tag, c), ser_data, e);
                end
            end
            chk($sformatf("%s ack one-hot c%0d", tag, c), {9'd0, ack_a && ack_b}, 10'd0);
            if (ack_a) acks_a++;
            if (ack_b) acks_b++;
            tick();
        end
        chk({tag, " frames left"}, 10'(exp_q.size()), 10'd0);
        exp_q.delete();
        req_a     = 1'b0;
        req_b     = 1'b0;
        ser_ready = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic       req_a;
        logic [7:0] data_a;
        logic       req_b;
        logic [7:0] data_b;
        logic       ser_ready;
        logic       exp_ack_a;
        logic       exp_ack_b;
        logic       exp_valid;
        logic [9:0] exp_data;
        logic       chk_data;
    } vec_t;

    vec_t vecs[24];

    initial begin
        int aa;
        int ab;
        n_vec  = 0;
        n_fail = 0;

        //          rst  ra  da     rb  db     rdy  ack_a ack_b vld  data    chk
        vecs[0]  = '{1'b0, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b1}; // reset: no ack
        vecs[1]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0}; // sync loads first
        vecs[2]  = '{1'b1, 1'b1, 8'h3C, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 10'h3A5, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'h3D, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 10'h13C, 1'b1};
        for (int i = 4; i <= 8; i++) begin                                                     // stall 5 cycles
            vecs[i] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1, 10'h13D, 1'b1};
        end
        vecs[9]  = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h77, 1'b1, 1'b0, 1'b1, 1'b1, 10'h13D, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h88, 1'b1, 1'b0, 1'b1, 1'b1, 10'h277, 1'b1};
        vecs[11] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0, 1'b0, 1'b1, 10'h288, 1'b1}; // 4th data -> sync
        vecs[12] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h99, 1'b1, 1'b0, 1'b1, 1'b1, 10'h3A5, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h299, 1'b1}; // drain to idle
        vecs[14] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};
        vecs[15] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0}; // empty: same-cycle ack
        vecs[16] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h15A, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 8'h11, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h15A, 1'b1}; // req while stalled
        vecs[18] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h15A, 1'b1}; // withdrawn: ignored
        vecs[19] = '{1'b1, 1'b1, 8'h22, 1'b1, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0, 10'h000, 1'b0}; // audio wins
        vecs[20] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h33, 1'b1, 1'b0, 1'b1, 1'b1, 10'h122, 1'b1};
        vecs[21] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h233, 1'b1}; // sync with no reqs
        vecs[22] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h3A5, 1'b1};
        vecs[23] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000, 1'b0};

        reset_dut();
        rst_n = 1'b0;
        for (int i = 0; i < 24; i++) begin
            rst_n     = vecs[i].rst_n;
            req_a     = vecs[i].req_a;
            data_a    = vecs[i].data_a;
            req_b     = vecs[i].req_b;
            data_b    = vecs[i].data_b;
            ser_ready = vecs[i].ser_ready;
            @(negedge clk_100mhz);
            chk($sformatf("v%0d ack_a", i), {9'd0, ack_a}, {9'd0, vecs[i].exp_ack_a});
            chk($sformatf("v%0d ack_b", i), {9'd0, ack_b}, {9'd0, vecs[i].exp_ack_b});
            chk($sformatf("v%0d ser_valid", i), {9'd0, ser_valid}, {9'd0, vecs[i].exp_valid});
            if (vecs[i].chk_data) begin
                chk($sformatf("v%0d ser_data", i), ser_data, vecs[i].exp_data);
            end
            tick();
        end

        // ---- bulk only, sync every 4 data frames ----
        reset_dut();
        exp_q = {10'h3A5, 10'h2BB, 10'h2BB, 10'h2BB, 10'h2BB,
                 10'h3A5, 10'h2BB, 10'h2BB, 10'h2BB, 10'h2BB};
        run_stream("bulk", 11, 1'b0, 1'b1, aa, ab);
        chk("bulk ack_b count", 10'(ab), 10'd8);
        chk("bulk ack_a count", 10'(aa), 10'd0);

        // ---- both requesters held ----
        reset_dut();
`ifdef OPTICAL_TX_FAIR_EN
        exp_q = {10'h3A5, 10'h1AA, 10'h1AA, 10'h1AA, 10'h1AA, 10'h3A5, 10'h2BB,
                 10'h1AA, 10'h1AA, 10'h1AA, 10'h3A5, 10'h1AA, 10'h2BB};
        run_stream("both", 14, 1'b1, 1'b1, aa, ab);
        chk("both ack_a count", 10'(aa), 10'd9);
        chk("both ack_b count", 10'(ab), 10'd2);
`else
        exp_q = {10'h3A5, 10'h1AA, 10'h1AA, 10'h1AA, 10'h1AA, 10'h3A5, 10'h1AA,
                 10'h1AA, 10'h1AA, 10'h1AA, 10'h3A5, 10'h1AA, 10'h1AA};
        run_stream("both", 14, 1'b1, 1'b1, aa, ab);
        chk("both ack_a count", 10'(aa), 10'd11);
        chk("both ack_b count", 10'(ab), 10'd0);
`endif

        // ---- reset while a bulk frame is stalled ----
        reset_dut();
        req_b     = 1'b1;
        data_b    = 8'h4B;
        ser_ready = 1'b1;
        @(negedge clk_100mhz);
        chk("rst_mid c0 ack_b", {9'd0, ack_b}, 10'd0);
        tick();
        @(negedge clk_100mhz);
        chk("rst_mid c1 data", ser_data, 10'h3A5);
        chk("rst_mid c1 ack_b", {9'd0, ack_b}, 10'd1);
        tick();
        ser_ready = 1'b0;
        rst_n     = 1'b0;
        @(negedge clk_100mhz);
        chk("rst_mid c2 held", ser_data, 10'h24B);
        chk("rst_mid c2 ack_b", {9'd0, ack_b}, 10'd0);
        tick();
        rst_n     = 1'b1;
        ser_ready = 1'b1;
        @(negedge clk_100mhz);
        chk("rst_mid c3 valid", {9'd0, ser_valid}, 10'd0);
        chk("rst_mid c3 data", ser_data, 10'h000);
        chk("rst_mid c3 ack_b", {9'd0, ack_b}, 10'd0);
        tick();
        @(negedge clk_100mhz);
        chk("rst_mid c4 valid", {9'd0, ser_valid}, 10'd1);
        chk("rst_mid c4 data", ser_data, 10'h3A5);
        chk("rst_mid c4 ack_b", {9'd0, ack_b}, 10'd1);
        tick();
        req_b = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/optical_tx_arbiter.md
OPTICAL_TX_ARBITER -- requirements
Module: optical_tx_arbiter

Interface
REQ-001 The block SHALL have parameter SYNC_PERIOD, default 64, meaning the number of data frames between forced sync frames (range 2..255).
REQ-002 The block SHALL have parameter SYNC_WORD, default 8'hA5, meaning the payload of a sync frame.
REQ-003 The block SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive audio grants while bulk waits (range 1..15).
REQ-004 clk_100mhz  input  1  system clock; all logic is on its rising edge.
REQ-005 rst_n  input  1  reset; synchronous and active-low, with one clock domain only.
REQ-006 req_a  input  1  audio requester has a word on data_a.
REQ-007 data_a  input  8  audio payload; held stable while req_a=1 until ack_a.
REQ-008 ack_a  output  1  one-cycle pulse: data_a captured this cycle.
REQ-009 req_b  input  1  bulk/SD requester has a word on data_b.
REQ-010 data_b  input  8  bulk payload; held stable while req_b=1 until ack_b.
REQ-011 ack_b  output  1  one-cycle pulse: data_b captured this cycle.
REQ-012 ser_valid  output  1  ser_data holds a frame for the optical serializer.
REQ-013 ser_data  output  10  frame {tag[1:0], payload[7:0]}.
REQ-014 ser_ready  input  1  serializer accepts ser_data this cycle when ser_valid=1.

Function
REQ-015 Tags SHALL be 2'b01 for an audio frame, 2'b10 for a bulk frame and 2'b11 for a sync frame; 2'b00 SHALL never be emitted with ser_valid=1.
REQ-016 A single output register SHALL be used: load = !ser_valid || ser_ready; the register SHALL be written only on load.
REQ-017 ser_valid=1 SHALL hold ser_data stable until ser_ready=1; ser_valid SHALL never drop without a transfer except on reset.
REQ-018 On load, the selection SHALL be in priority order: (1) sync if sync_due, (2) bulk if fairness forces it (REQ-023), (3) audio if req_a, (4) bulk if req_b, (5) nothing (ser_valid<=0).
REQ-019 ack_a/ack_b SHALL be combinational, equal to load AND the respective grant, and at most one of them SHALL be high per cycle; a sync load SHALL ack neither.
REQ-020 Latency: a request arriving at cycle n with the register empty SHALL be acked at n, with ser_valid=1 at n+1; with ser_ready held at 1, one frame per cycle SHALL sustain back-to-back.
REQ-021 A frame counter SHALL count data-frame loads; on the load at which it equals SYNC_PERIOD, a sync frame SHALL load instead and the counter SHALL clear to 0. sync_due = (count==SYNC_PERIOD) || first_after_reset.
REQ-022 A sync SHALL take precedence even while requests are pending; requesters simply wait one more load slot.
REQ-023 Burst counter (fairness feature only): it SHALL increment on each audio grant made while req_b=1, clear on any bulk grant or when req_b=0, and force a bulk grant when it equals MAX_BURST and req_b=1.
REQ-024 A request deasserted before ack SHALL be ignored; no state SHALL change on its account.
REQ-025 State machine: IDLE (ser_valid=0), HOLD (ser_valid=1, waiting for ser_ready); IDLE->HOLD on any selection, HOLD->IDLE on transfer with nothing selected, HOLD->HOLD on transfer with a new selection or while ser_ready=0.

Reset
REQ-026 While rst_n=0 at a clock edge: ser_valid=0, ser_data=10'h000, frame counter=0, burst counter=0, first_after_reset=1; ack_a=ack_b=0 during reset regardless of load.
REQ-027 Reset mid-frame SHALL discard the held frame with no ack and no replay; the first load after reset SHALL be a sync frame.

Configuration
REQ-028 Macro OPTICAL_TX_FAIR_EN: when defined, the burst counter and the forced bulk grant (REQ-023) SHALL be compiled in.
REQ-029 When OPTICAL_TX_FAIR_EN is undefined, arbitration SHALL be strict audio priority, and bulk SHALL be granted only when req_a=0 at load.

Verification
REQ-030 Reset, then ser_ready=1 and req_a=1 with data_a=8'h3C: the first frame SHALL be 10'h3A5 (sync) with no ack, then 10'h13C with ack_a in the same cycle it loads.
REQ-031 ser_ready=0 for 5 cycles with a frame held: ser_data and ser_valid SHALL be unchanged and no ack SHALL occur; on ser_ready=1 the next word SHALL load in that cycle.
REQ-032 SYNC_PERIOD=4 with req_b held at 1 and ser_ready=1: the frame sequence SHALL be sync, 4 bulk, sync, 4 bulk, with ack_b pulsing 8 times.
REQ-033 With OPTICAL_TX_FAIR_EN defined, MAX_BURST=4 and req_a and req_b held at 1: after the initial sync the sequence SHALL be 4 audio then 1 bulk, repeating; without the macro it SHALL be audio only.
REQ-034 Assert rst_n=0 for 1 cycle while a bulk frame is held with ser_ready=0: ser_valid SHALL be 0 the next cycle and the next frame after release SHALL be sync.
